// File: rtl/write_trace_checker.sv
// Snoops the CHIP write-observation stream, waits for a trigger write, then
// checks following writes against a preloaded expected list.
module write_trace_checker #(
   parameter int                ADDR_W     = 30,
   parameter int                DATA_W     = 32,
   parameter int                DEPTH      = 64,
   parameter logic [ADDR_W-1:0] START_ADDR = '0,
   parameter int                TIMEOUT    = 10000,
   parameter int                ORDERED    = 1,
   parameter int                ERR_W      = 8,
   parameter int                DUR_W      = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ld_valid,
   input  logic [ADDR_W-1:0]          ld_addr,
   input  logic [DATA_W-1:0]          ld_data,
   input  logic                       go,
   input  logic                       wen,
   input  logic [ADDR_W-1:0]          addr,
   input  logic [DATA_W-1:0]          data,
   output logic [ERR_W-1:0]           error_num,
   output logic [DUR_W-1:0]           duration,
   output logic                       finish,
   output logic                       timeout,
   output logic                       ld_overflow,
   output logic [$clog2(DEPTH)-1:0]   first_err_idx,
   output logic [2:0]                 state
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_CHECK = 3'd2,
      S_DONE  = 3'd3,
      S_TOUT  = 3'd4
   } state_t;

   state_t cur, nxt;

   logic [ADDR_W-1:0] mem_addr [DEPTH];
   logic [DATA_W-1:0] mem_data [DEPTH];

   logic [CW-1:0]     cnt, rp, rp_nxt;
   logic [DUR_W-1:0]  dur_nxt;
   logic [ADDR_W-1:0] exp_addr;
   logic [DATA_W-1:0] exp_data;
   logic              eligible, mismatch, load_ok, list_full;

   assign list_full = (cnt == CW'(DEPTH));
   assign load_ok   = (cur == S_IDLE) && ld_valid && !list_full;
   assign exp_addr  = mem_addr[rp[IW-1:0]];
   assign exp_data  = mem_data[rp[IW-1:0]];
   // In unordered mode only writes aimed at the current expected address count.
   assign eligible  = wen && ((ORDERED != 0) || (addr == exp_addr));
   assign mismatch  = (addr != exp_addr) || (data != exp_data);
   assign rp_nxt    = rp + {{(CW-1){1'b0}}, eligible};
   assign dur_nxt   = duration + DUR_W'(1);
   assign state     = cur;

   always_ff @(posedge clk) begin
      if (load_ok) begin
         mem_addr[cnt[IW-1:0]] <= ld_addr;
         mem_data[cnt[IW-1:0]] <= ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cur <= S_IDLE;
      else     cur <= nxt;
   end

   // Completion is tested before timeout so a last write on the final cycle wins.
   always_comb begin
      nxt = cur;
      case (cur)
         S_IDLE:  if (go) nxt = (cnt == '0) ? S_DONE : S_WAIT;
         S_WAIT:  if (wen && (addr == START_ADDR)) nxt = S_CHECK;
         S_CHECK: begin
            if (rp_nxt == cnt)                   nxt = S_DONE;
            else if (dur_nxt == DUR_W'(TIMEOUT)) nxt = S_TOUT;
         end
         default: nxt = cur;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt           <= '0;
         rp            <= '0;
         error_num     <= '0;
         duration      <= '0;
         finish        <= 1'b0;
         timeout       <= 1'b0;
         ld_overflow   <= 1'b0;
         first_err_idx <= '0;
      end else begin
         finish  <= (nxt == S_DONE) || (nxt == S_TOUT);
         timeout <= (nxt == S_TOUT);
         if (load_ok) cnt <= cnt + CW'(1);
         if ((cur == S_IDLE) && ld_valid && list_full) ld_overflow <= 1'b1;
         if ((cur == S_IDLE) && go) rp <= '0;
         if (cur == S_CHECK) begin
            duration <= dur_nxt;
            if (eligible) begin
               rp <= rp_nxt;
               if (mismatch) begin
                  if (error_num == '0) first_err_idx <= rp[IW-1:0];
                  if (error_num != '1) error_num <= error_num + ERR_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_write_trace_checker.sv
// Bench for write_trace_checker: an ordered short-timeout instance and an
// unordered instance share stimulus and are both tracked by a list-based model.
module tb_write_trace_checker;

   logic        clk = 1'b0;
   logic        rst, ld_valid, go, wen;
   logic [29:0] ld_addr, addr;
   logic [31:0] ld_data, data;

   logic [7:0]  err_o, err_u;
   logic [15:0] dur_o, dur_u;
   logic        fin_o, fin_u, to_o, to_u, ovf_o, ovf_u;
   logic [1:0]  fei_o, fei_u;
   logic [2:0]  st_o, st_u;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   write_trace_checker #(.DEPTH(4), .TIMEOUT(4), .ORDERED(1)) u_ord (
      .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
      .go(go), .wen(wen), .addr(addr), .data(data),
      .error_num(err_o), .duration(dur_o), .finish(fin_o), .timeout(to_o),
      .ld_overflow(ovf_o), .first_err_idx(fei_o), .state(st_o));

   write_trace_checker #(.DEPTH(4), .TIMEOUT(64), .ORDERED(0)) u_unord (
      .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
      .go(go), .wen(wen), .addr(addr), .data(data),
      .error_num(err_u), .duration(dur_u), .finish(fin_u), .timeout(to_u),
      .ld_overflow(ovf_u), .first_err_idx(fei_u), .state(st_u));

   // Reference model: expected list as a queue, phases 0..4 as in the state output.
   logic [61:0] exp_q[$];
   bit          m_ovf;
   int          m_phase[2], m_idx[2], m_err[2], m_dur[2], m_first[2];
   int          m_to[2]  = '{4, 64};
   bit          m_ord[2] = '{1'b1, 1'b0};

   task automatic model_step();
      int pre;
      bit was_idle;
      pre = exp_q.size();
      if (rst) begin
         exp_q.delete();
         m_ovf = 0;
         for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_idx[i] = 0; m_err[i] = 0; m_dur[i] = 0; m_first[i] = 0;
         end
         return;
      end
      was_idle = (m_phase[0] == 0);
      for (int i = 0; i < 2; i++) begin
         case (m_phase[i])
            0: if (go) begin m_phase[i] = (pre == 0) ? 3 : 1; m_idx[i] = 0; end
            1: if (wen && addr == 30'd0) m_phase[i] = 2;
            2: begin
               m_dur[i]++;
               if (wen && (m_ord[i] || addr == exp_q[m_idx[i]][61:32])) begin
                  if ({addr, data} != exp_q[m_idx[i]]) begin
                     if (m_err[i] == 0) m_first[i] = m_idx[i];
                     if (m_err[i] < 255) m_err[i]++;
                  end
                  m_idx[i]++;
               end
               if (m_idx[i] == pre)          m_phase[i] = 3;
               else if (m_dur[i] == m_to[i]) m_phase[i] = 4;
            end
            default: ;
         endcase
      end
      if (was_idle && ld_valid) begin
         if (pre < 4) exp_q.push_back({ld_addr, ld_data});
         else         m_ovf = 1;
      end
   endtask

   task automatic checkOutput(input string name, input longint act, input longint exp);
      nvec++;
      if (act != exp) begin
         nmis++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_model();
      checkOutput("ord.state",    st_o,  m_phase[0]);
      checkOutput("ord.err",      err_o, m_err[0]);
      checkOutput("ord.dur",      dur_o, m_dur[0]);
      checkOutput("ord.finish",   fin_o, (m_phase[0] >= 3) ? 1 : 0);
      checkOutput("ord.timeout",  to_o,  (m_phase[0] == 4) ? 1 : 0);
      checkOutput("ord.ovf",      ovf_o, m_ovf);
      checkOutput("ord.fei",      fei_o, m_first[0]);
      checkOutput("unord.state",  st_u,  m_phase[1]);
      checkOutput("unord.err",    err_u, m_err[1]);
      checkOutput("unord.dur",    dur_u, m_dur[1]);
      checkOutput("unord.finish", fin_u, (m_phase[1] >= 3) ? 1 : 0);
      checkOutput("unord.timeout",to_u,  (m_phase[1] == 4) ? 1 : 0);
      checkOutput("unord.ovf",    ovf_u, m_ovf);
      checkOutput("unord.fei",    fei_u, m_first[1]);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_model();
      rst = 0; ld_valid = 0; go = 0; wen = 0;
   endtask

   task automatic do_reset();        rst = 1; tick(); endtask
   task automatic do_go();           go = 1; tick(); endtask
   task automatic ld(input int a, input int d);
      ld_valid = 1; ld_addr = 30'(a); ld_data = 32'(d); tick();
   endtask
   task automatic wr(input int a, input int d);
      wen = 1; addr = 30'(a); data = 32'(d); tick();
   endtask
   task automatic load3(); ld(5, 1); ld(6, 2); ld(7, 3); endtask

   typedef struct {
      logic        rst, ldv, go, wen;
      logic [29:0] la, a;
      logic [31:0] ld, d;
      logic [2:0]  st;
      logic [7:0]  err;
      logic [15:0] dur;
      logic        fin, to;
   } vec_t;

   vec_t tbl[10];

   function automatic vec_t mk(input logic r, input logic lv, input int la, input int ldd,
                               input logic g, input logic w, input int a, input int d,
                               input int st, input int err, input int dur, input logic fin,
                               input logic to);
      vec_t v;
      v.rst = r; v.ldv = lv; v.la = 30'(la); v.ld = 32'(ldd); v.go = g; v.wen = w;
      v.a = 30'(a); v.d = 32'(d); v.st = 3'(st); v.err = 8'(err); v.dur = 16'(dur);
      v.fin = fin; v.to = to;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      rst = v.rst; ld_valid = v.ldv; ld_addr = v.la; ld_data = v.ld;
      go = v.go; wen = v.wen; addr = v.a; data = v.d;
   endtask

   initial begin
      rst = 0; ld_valid = 0; go = 0; wen = 0;
      ld_addr = '0; ld_data = '0; addr = '0; data = '0;
      foreach (m_phase[i]) begin
         m_phase[i] = 0; m_idx[i] = 0; m_err[i] = 0; m_dur[i] = 0; m_first[i] = 0;
      end
      m_ovf = 0;

      // Clean run: three matching writes after the trigger.
      tbl[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[1] = mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[2] = mk(0, 1, 6, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[3] = mk(0, 1, 7, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[4] = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[5] = mk(0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0);
      tbl[6] = mk(0, 0, 0, 0, 0, 1, 5, 1, 2, 0, 1, 0, 0);
      tbl[7] = mk(0, 0, 0, 0, 0, 1, 6, 2, 2, 0, 2, 0, 0);
      tbl[8] = mk(0, 0, 0, 0, 0, 1, 7, 3, 3, 0, 3, 1, 0);
      tbl[9] = mk(0, 0, 0, 0, 0, 1, 7, 9, 3, 0, 3, 1, 0);

      for (int k = 0; k < 10; k++) begin
         applyStimulus(tbl[k]);
         tick();
         checkOutput("tbl.state", st_o,  tbl[k].st);
         checkOutput("tbl.err",   err_o, tbl[k].err);
         checkOutput("tbl.dur",   dur_o, tbl[k].dur);
         checkOutput("tbl.fin",   fin_o, tbl[k].fin);
         checkOutput("tbl.to",    to_o,  tbl[k].to);
      end

      // Single data mismatch on the second entry.
      do_reset(); load3(); do_go(); wr(0, 0); wr(5, 1); wr(6, 9); wr(7, 3);
      checkOutput("mis.err", err_o, 1);
      checkOutput("mis.fei", fei_o, 1);
      checkOutput("mis.state", st_o, 3);

      // Interleaved writes to address 20: ignored unordered, counted ordered.
      do_reset(); load3(); do_go(); wr(0, 0);
      wr(20, 0); wr(5, 1); wr(20, 0); wr(6, 2); wr(20, 0); wr(7, 3);
      checkOutput("ilv.ord.err",   err_o, 3);
      checkOutput("ilv.ord.dur",   dur_o, 3);
      checkOutput("ilv.ord.fei",   fei_o, 0);
      checkOutput("ilv.unord.err", err_u, 0);
      checkOutput("ilv.unord.dur", dur_u, 6);
      checkOutput("ilv.unord.st",  st_u,  3);

      // Timeout with no writes after the trigger.
      do_reset(); load3(); do_go(); wr(0, 0);
      tick(); tick(); tick();
      checkOutput("to.pre.state", st_o, 2);
      checkOutput("to.pre.fin",   fin_o, 0);
      tick();
      checkOutput("to.state", st_o, 4);
      checkOutput("to.dur",   dur_o, 4);
      checkOutput("to.fin",   fin_o, 1);
      checkOutput("to.to",    to_o, 1);
      wr(5, 1);
      checkOutput("to.frozen", dur_o, 4);

      // Last entry lands exactly on the timeout cycle: completion wins.
      do_reset(); load3(); do_go(); wr(0, 0); wr(5, 1); tick(); wr(6, 2); wr(7, 3);
      checkOutput("race.state", st_o, 3);
      checkOutput("race.dur",   dur_o, 4);
      checkOutput("race.to",    to_o, 0);

      // Overflow: five loads into a four-entry list.
      do_reset();
      for (int i = 1; i <= 5; i++) ld(i, i);
      checkOutput("ovf.flag", ovf_o, 1);
      do_go(); wr(0, 0); wr(1, 1); wr(2, 2); wr(3, 3); wr(4, 4);
      checkOutput("ovf.state", st_o, 3);
      checkOutput("ovf.dur",   dur_o, 4);
      checkOutput("ovf.err",   err_o, 0);
      do_reset(); do_go();
      checkOutput("empty.state", st_o, 3);
      checkOutput("empty.err",   err_o, 0);

      // Reset in the middle of checking.
      do_reset(); load3(); do_go(); wr(0, 0); wr(5, 9); wr(6, 9);
      checkOutput("mid.err", err_o, 2);
      do_reset();
      checkOutput("mid.rst.state", st_o, 0);
      checkOutput("mid.rst.err",   err_o, 0);
      checkOutput("mid.rst.dur",   dur_o, 0);
      checkOutput("mid.rst.fei",   fei_o, 0);
      do_go();
      checkOutput("mid.go.state", st_o, 3);

      // Randomized traffic against the model.
      for (int it = 0; it < 40; it++) begin
         int n;
         do_reset();
         n = $urandom_range(0, 5);
         for (int j = 0; j < n; j++) begin
            ld_valid = 1;
            ld_addr  = 30'($urandom_range(1, 6));
            ld_data  = 32'($urandom_range(0, 3));
            if (j == n - 1 && ($urandom % 2) == 1) go = 1;
            tick();
         end
         do_go();
         for (int c = 0; c < 20; c++) begin
            wen      = ($urandom % 4) != 0;
            addr     = 30'($urandom_range(0, 6));
            data     = 32'($urandom_range(0, 3));
            ld_valid = ($urandom % 8) == 0;
            ld_addr  = 30'($urandom_range(1, 6));
            ld_data  = 32'($urandom_range(0, 3));
            go       = ($urandom % 16) == 0;
            rst      = ($urandom % 64) == 0;
            tick();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
